// File: rtl/soin_bpred_update_ctrl.sv
// rtl/soin_bpred_update_ctrl.sv - write-port controller for the bimodal 2-bit counter table
//
// Purpose: single owner of the predictor table write port. After reset or a
// flush it sweeps every entry to INIT_CTR. It buffers branch-resolution
// updates in an in-order FIFO and drains one per unstalled RUN cycle, writing
// the saturated next-counter value.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   stall            blocks draining in RUN (ignored during the sweep)
//   up_valid/ready   update handshake from execute
//   up_index/ctr/dir resolved branch index, counter read at predict, direction
//   flush_req        one-cycle pulse, restart the sweep and drop pending updates
//   wr_en/addr/data  registered table write port
//   init_busy        registered, high while the sweep runs
//   fifo_count       current FIFO occupancy
//   applied_count    updates written in RUN (wraps)
module soin_bpred_update_ctrl #(
  parameter int         INDEX_W    = 9,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_CTR   = 2'b00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic [INDEX_W-1:0]            up_index,
  input  logic [1:0]                    up_ctr,
  input  logic                          up_dir,
  input  logic                          flush_req,
  output logic                          wr_en,
  output logic [INDEX_W-1:0]            wr_addr,
  output logic [1:0]                    wr_data,
  output logic                          init_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   applied_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state, state_nxt;
  logic [INDEX_W-1:0]   sweep_idx, sweep_idx_nxt;
  logic [PTR_W-1:0]     rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic                 wr_en_nxt;
  logic [INDEX_W-1:0]   wr_addr_nxt;
  logic [1:0]           wr_data_nxt;
  logic                 init_busy_nxt;
  logic [31:0]          applied_nxt;

  logic [INDEX_W-1:0]   q_index [FIFO_DEPTH];
  logic [1:0]           q_ctr   [FIFO_DEPTH];
  logic                 q_dir   [FIFO_DEPTH];

  logic push;
  logic pop;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic d);
    if (d) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Ready looks only at the registered count, so a full FIFO never admits a
  // push even when a pop happens in the same cycle.
  assign up_ready   = (count < DEPTH_C);
  assign fifo_count = count;

  // A flush cycle drops both the incoming push and any pop.
  assign push = up_valid & up_ready & ~flush_req;
  assign pop  = (state == ST_RUN) & ~stall & (count != '0) & ~flush_req;

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    init_busy_nxt = init_busy;
    rd_ptr_nxt    = rd_ptr;
    wr_ptr_nxt    = wr_ptr;
    count_nxt     = count;
    applied_nxt   = applied_count;

    if (flush_req) begin
      state_nxt     = ST_INIT;
      sweep_idx_nxt = '0;
      init_busy_nxt = 1'b1;
      rd_ptr_nxt    = '0;
      wr_ptr_nxt    = '0;
      count_nxt     = '0;
    end else begin
      case (state)
        ST_INIT: begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = sweep_idx;
          wr_data_nxt = INIT_CTR;
          if (sweep_idx == LAST_IDX) begin
            state_nxt     = ST_RUN;
            sweep_idx_nxt = '0;
            init_busy_nxt = 1'b0;
          end else begin
            sweep_idx_nxt = sweep_idx + INDEX_W'(1);
          end
        end
        ST_RUN: begin
          if (pop) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = q_index[rd_ptr];
            wr_data_nxt = sat(q_ctr[rd_ptr], q_dir[rd_ptr]);
            applied_nxt = applied_count + 32'd1;
          end
        end
        default: state_nxt = ST_INIT;
      endcase

      // Pointers wrap naturally since the depth is a power of two.
      if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_INIT;
      sweep_idx     <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= 2'b00;
      init_busy     <= 1'b1;
      applied_count <= 32'd0;
    end else begin
      state         <= state_nxt;
      sweep_idx     <= sweep_idx_nxt;
      rd_ptr        <= rd_ptr_nxt;
      wr_ptr        <= wr_ptr_nxt;
      count         <= count_nxt;
      wr_en         <= wr_en_nxt;
      wr_addr       <= wr_addr_nxt;
      wr_data       <= wr_data_nxt;
      init_busy     <= init_busy_nxt;
      applied_count <= applied_nxt;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_index[wr_ptr] <= up_index;
      q_ctr[wr_ptr]   <= up_ctr;
      q_dir[wr_ptr]   <= up_dir;
    end
  end

endmodule

// File: tb/tb_soin_bpred_update_ctrl.sv
// tb/tb_soin_bpred_update_ctrl.sv - randomized self-checking bench for soin_bpred_update_ctrl
module tb_soin_bpred_update_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [8:0]  up_index = '0;
  logic [1:0]  up_ctr = '0;
  logic        up_dir = 1'b0;
  logic        flush_req = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        init_busy;
  logic [2:0]  fifo_count;
  logic [31:0] applied_count;

  soin_bpred_update_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .up_valid(up_valid), .up_ready(up_ready), .up_index(up_index),
    .up_ctr(up_ctr), .up_dir(up_dir), .flush_req(flush_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(init_busy), .fifo_count(fifo_count), .applied_count(applied_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending updates plus the sweep position.
  typedef struct {
    logic [8:0] idx;
    logic [1:0] ctr;
    logic       dir;
  } upd_t;

  upd_t        mq[$];
  bit          m_run;
  int          m_sidx;
  logic        m_wr_en;
  logic [8:0]  m_addr;
  logic [1:0]  m_data;
  logic        m_busy;
  logic [31:0] m_applied;

  logic [1:0] sat_tbl [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3};

  function automatic logic [1:0] m_sat(input logic [1:0] c, input logic d);
    int v;
    v = d ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_sidx = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
    m_busy = 1; m_applied = '0;
  endtask

  task automatic model_edge(input logic v, input logic [8:0] idx, input logic [1:0] c,
                            input logic d, input logic st, input logic fl);
    bit   accept;
    upd_t e;
    if (fl) begin
      m_run = 0; m_sidx = 0; mq.delete(); m_busy = 1; m_wr_en = 0;
    end else begin
      accept = v && (mq.size() < 4);
      if (!m_run) begin
        m_wr_en = 1; m_addr = 9'(m_sidx); m_data = 2'b00;
        if (m_sidx == 511) begin
          m_run = 1; m_sidx = 0; m_busy = 0;
        end else begin
          m_sidx++;
        end
      end else if (!st && mq.size() > 0) begin
        e = mq.pop_front();
        m_wr_en = 1; m_addr = e.idx; m_data = m_sat(e.ctr, e.dir);
        m_applied = m_applied + 32'd1;
      end else begin
        m_wr_en = 0;
      end
      if (accept) begin
        e.idx = idx; e.ctr = c; e.dir = d;
        mq.push_back(e);
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic v, input logic [8:0] idx, input logic [1:0] c,
                      input logic d, input logic st, input logic fl);
    up_valid = v; up_index = idx; up_ctr = c; up_dir = d; stall = st; flush_req = fl;
    #1;
    check("up_ready", {31'b0, up_ready}, {31'b0, (mq.size() < 4)});
    model_edge(v, idx, c, d, st, fl);
    @(posedge clk);
    #1;
    check("wr_en", {31'b0, wr_en}, {31'b0, m_wr_en});
    check("wr_addr", {23'b0, wr_addr}, {23'b0, m_addr});
    check("wr_data", {30'b0, wr_data}, {30'b0, m_data});
    check("init_busy", {31'b0, init_busy}, {31'b0, m_busy});
    check("fifo_count", {29'b0, fifo_count}, 32'(mq.size()));
    check("applied_count", applied_count, m_applied);
    @(negedge clk);
    up_valid = 0; flush_req = 0;
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 2'd0, 1'b0, st, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {23'b0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {30'b0, wr_data}, 32'd0);
    check({tag, "_init_busy"}, {31'b0, init_busy}, 32'd1);
    check({tag, "_fifo_count"}, {29'b0, fifo_count}, 32'd0);
    check({tag, "_up_ready"}, {31'b0, up_ready}, 32'd1);
  endtask

  logic [31:0] applied_snap;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_applied", applied_count, 32'd0);
    reset = 0;

    // Initial sweep with no updates.
    idle(512, 1'b0);
    check("sweep_last_addr", {23'b0, wr_addr}, 32'd511);
    check("sweep_busy_low", {31'b0, init_busy}, 32'd0);
    idle(1, 1'b0);
    check("sweep_done_wr_en", {31'b0, wr_en}, 32'd0);

    // Same index twice, each with its own captured counter.
    step(1'b1, 9'd5, 2'b01, 1'b1, 1'b0, 1'b0);
    step(1'b1, 9'd5, 2'b11, 1'b0, 1'b0, 1'b0);
    check("same_idx_a_addr", {23'b0, wr_addr}, 32'd5);
    check("same_idx_a_data", {30'b0, wr_data}, 32'd2);
    idle(1, 1'b0);
    check("same_idx_b_addr", {23'b0, wr_addr}, 32'd5);
    check("same_idx_b_data", {30'b0, wr_data}, 32'd2);
    check("same_idx_applied", applied_count, 32'd2);

    // Stall fills the FIFO; 6 offers, 4 accepted.
    for (int i = 0; i < 6; i++)
      step(1'b1, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("stall_full_count", {29'b0, fifo_count}, 32'd4);
    check("stall_full_ready", {31'b0, up_ready}, 32'd0);
    idle(6, 1'b0);

    // All eight {dir, ctr} combinations.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 9'(k + 100), 2'(k), 1'(k >> 2), 1'b0, 1'b0);
      idle(1, 1'b0);
      check("sat_tbl", {30'b0, wr_data}, {30'b0, sat_tbl[k]});
    end

    // Flush with 3 entries pending.
    for (int i = 0; i < 3; i++) step(1'b1, 9'(i + 20), 2'd1, 1'b1, 1'b1, 1'b0);
    applied_snap = applied_count;
    step(1'b1, 9'd33, 2'd2, 1'b1, 1'b0, 1'b1);
    check("flush_count", {29'b0, fifo_count}, 32'd0);
    check("flush_wr_en", {31'b0, wr_en}, 32'd0);
    check("flush_busy", {31'b0, init_busy}, 32'd1);
    idle(1, 1'b0);
    check("flush_sweep_addr0", {23'b0, wr_addr}, 32'd0);
    idle(511, 1'b0);
    check("flush_applied", applied_count, applied_snap);
    check("flush_sweep_end", {23'b0, wr_addr}, 32'd511);

    // Async reset mid-sweep with 2 entries queued.
    step(1'b1, 9'd7, 2'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 9'd8, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'd9, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600 && m_addr != 9'd200; i++) idle(1, 1'b0);
    check("pre_rst_addr", {23'b0, wr_addr}, 32'd200);
    check("pre_rst_count", {29'b0, fifo_count}, 32'd2);
    #2;
    reset = 1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    reset = 0;
    idle(1, 1'b0);
    check("post_rst_addr0", {23'b0, wr_addr}, 32'd0);
    idle(520, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), ($urandom_range(0, 299) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
